// File: rtl/memory_access_pkg.sv
// Shared types for the memory (M) stage: pipeline records, data bus
// request/response records, access sizes and the M-stage state encoding.
package memory_access_pkg;

    localparam int XLEN       = 64;
    localparam int LINE_BYTES = 8;

    typedef logic [XLEN-1:0] u64;

    // Access size as carried in the control word (log2 of the byte count)
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    // M-stage bus sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic   RegWrite;
        logic   MemRead;
        logic   MemWrite;
        logic   MemUnsigned;
        msize_t msize;
    } control_t;

    typedef struct packed {
        u64       pc;
        control_t ctl;
        u64       alu;
        u64       rs2;
        logic     valid;
    } execute_data_t;

    typedef struct packed {
        logic       valid;
        u64         addr;
        msize_t     size;
        logic [7:0] strobe;
        u64         data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    typedef struct packed {
        u64       pc;
        control_t ctl;
        u64       alu;
        u64       rd_data;
        logic     valid;
        logic     misalign;
    } memory_data_t;

    // Byte-enable pattern of an access that starts at byte 0 of the line
    function automatic logic [7:0] size_strobe(input msize_t size);
        logic [7:0] s;
        case (size)
            MSIZE1:  s = 8'h01;
            MSIZE2:  s = 8'h03;
            MSIZE4:  s = 8'h0F;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // An access must start on a multiple of its own size
    function automatic logic is_misaligned(input msize_t size, input logic [2:0] offset);
        logic m;
        case (size)
            MSIZE1:  m = 1'b0;
            MSIZE2:  m = offset[0];
            MSIZE4:  m = |offset[1:0];
            default: m = |offset[2:0];
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Byte-lane alignment for 8-byte data lines. Store side shifts write data and
// byte enables into place; load side pulls the addressed bytes down to bit 0
// and sign/zero extends them. Purely combinational so the cached and uncached
// paths can share it.
module mem_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  offset,
    input  msize_t      size,
    input  logic        is_unsigned,
    input  logic [63:0] store_data,
    input  logic [63:0] load_data,
    output logic [7:0]  strobe,
    output logic [63:0] store_data_aligned,
    output logic [63:0] load_data_ext,
    output logic        misalign
);

    logic [63:0] load_shifted;

    // Store side: move the low bytes of the source register to the addressed lanes
    always_comb begin
        strobe             = size_strobe(size) << offset;
        store_data_aligned = store_data << {offset, 3'b000};
        misalign           = is_misaligned(size, offset);
    end

    // Load side: bring the addressed lanes to the bottom and widen to 64 bits
    always_comb begin
        load_shifted  = load_data >> {offset, 3'b000};
        load_data_ext = load_shifted;
        case (size)
            MSIZE1: begin
                if (is_unsigned) load_data_ext = {56'd0, load_shifted[7:0]};
                else             load_data_ext = {{56{load_shifted[7]}}, load_shifted[7:0]};
            end
            MSIZE2: begin
                if (is_unsigned) load_data_ext = {48'd0, load_shifted[15:0]};
                else             load_data_ext = {{48{load_shifted[15]}}, load_shifted[15:0]};
            end
            MSIZE4: begin
                if (is_unsigned) load_data_ext = {32'd0, load_shifted[31:0]};
                else             load_data_ext = {{32{load_shifted[31]}}, load_shifted[31:0]};
            end
            default: load_data_ext = load_shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory (M) stage. Issues one data-bus transaction per load/store, holds the
// pipeline with mem_wait until the response is captured, and presents the
// result to writeback. Non-memory ops and misaligned accesses pass straight
// through with no added latency.
module memory_access
    import memory_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          stallM,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM_nxt,
    output logic          mem_wait
);

    mem_state_t  state_q;
    mem_state_t  state_d;
    logic [63:0] rbuf_q;
    logic [63:0] rbuf_d;

    logic        is_mem_op;
    logic        misalign;
    logic        access;
    logic [7:0]  strobe_aligned;
    logic [63:0] store_aligned;
    logic [63:0] load_ext;

    // data_ok already implies the address was taken, so addr_ok adds nothing here
    logic        unused_addr_ok;
    assign unused_addr_ok = dresp.addr_ok;

    mem_align u_align (
        .offset             (dataE.alu[2:0]),
        .size               (dataE.ctl.msize),
        .is_unsigned        (dataE.ctl.MemUnsigned),
        .store_data         (dataE.rs2),
        .load_data          (dresp.data),
        .strobe             (strobe_aligned),
        .store_data_aligned (store_aligned),
        .load_data_ext      (load_ext),
        .misalign           (misalign)
    );

    // Decide whether the instruction in M needs the bus at all
    always_comb begin
        is_mem_op = dataE.valid & (dataE.ctl.MemRead | dataE.ctl.MemWrite);
        access    = is_mem_op & ~misalign;
    end

    // Sequence IDLE -> REQ -> DONE and capture the extended load data on data_ok
    always_comb begin
        state_d = state_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: begin
                if (access) state_d = REQ;
            end
            REQ: begin
                if (dresp.data_ok) begin
                    state_d = DONE;
                    rbuf_d  = load_ext;
                end
            end
            DONE: begin
                if (!stallM) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response buffer registers; reset abandons any open transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Bus request is driven only from registered state and the held E/M record,
    // so there is no path from dresp back to dreq; reads carry an empty strobe
    always_comb begin
        dreq.valid  = (state_q == REQ) & ~reset;
        dreq.addr   = {dataE.alu[63:3], 3'b000};
        dreq.size   = dataE.ctl.msize;
        dreq.strobe = dataE.ctl.MemWrite ? strobe_aligned : 8'h00;
        dreq.data   = store_aligned;
    end

    // Result record for writeback and the upstream stall request
    always_comb begin
        dataM_nxt.pc       = dataE.pc;
        dataM_nxt.ctl      = dataE.ctl;
        dataM_nxt.alu      = dataE.alu;
        dataM_nxt.valid    = dataE.valid;
        dataM_nxt.misalign = is_mem_op & misalign;
        dataM_nxt.rd_data  = (state_q == DONE) ? rbuf_q : dataE.alu;
        mem_wait           = access & (state_q != DONE);
    end

endmodule
